seq_divider: RTL and testbench

- Sequential signed restoring divider; the inverse-operation companion to the Booth multiplier.
- Shares the multiplier's request/response style: operands are offered with valid_in, and the result is presented with valid_out.
- The block owns its FSM, iteration counter and sign-fix stage, plus an output hold with backpressure.
- Sits beside the multiplier in the arithmetic unit and is selected by the top level.

---
 rtl/arith_pkg.sv | 16 +
 rtl/div_step.sv | 28 ++
 rtl/seq_divider.sv | 153 +++++++++++++++
 tb/tb_seq_divider.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions used by the multiplier and the divider.
package arith_pkg;

   localparam int unsigned WIDTH_DEFAULT = 16;

   // Wide all-ones constant; consumers truncate it to their own width.
   localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift, trial subtract, restore.
module div_step #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH:0]   dvs_mag,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < dvs_mag <= 2^(WIDTH-1), so the shifted partial remainder fits WIDTH+1 bits
   assign shifted = {rem, quo[WIDTH-1]};
   assign trial   = shifted - dvs_mag;

   always_comb begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH]) begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider with valid/ready request and held, backpressured result.
module seq_divider
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready_in,
   output logic             valid_out,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH:0]   dvs_q, dvs_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_by_zero_q, div_by_zero_d;
   logic             valid_out_q, valid_out_d;
   logic             ready_in_q, ready_in_d;

   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH:0]   divisor_ext;
   logic [WIDTH:0]   divisor_mag;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic             out_hs;

   // |most-negative| wraps to 2^(WIDTH-1), which is still correct read as unsigned
   assign dividend_mag = dividend[WIDTH-1] ? (-dividend) : dividend;
   assign divisor_ext  = {divisor[WIDTH-1], divisor};
   assign divisor_mag  = divisor[WIDTH-1] ? (-divisor_ext) : divisor_ext;
   assign out_hs       = valid_out_q && out_ready;

   div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .dvs_mag  (dvs_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rem_d         = rem_q;
      quo_d         = quo_q;
      dvs_d         = dvs_q;
      sign_a_d      = sign_a_q;
      sign_b_d      = sign_b_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;

      case (state_q)
         IDLE: begin
            if (valid_in) begin
               sign_a_d      = dividend[WIDTH-1];
               sign_b_d      = divisor[WIDTH-1];
               quo_d         = dividend_mag;
               rem_d         = '0;
               dvs_d         = divisor_mag;
               cnt_d         = CNT_W'(WIDTH - 1);
               div_by_zero_d = (divisor == '0);
               if (divisor == '0) begin
                  quotient_d  = WIDTH'(DIV_ZERO_QUOTIENT);
                  remainder_d = dividend;
                  state_d     = DONE;
               end else begin
                  state_d     = CALC;
               end
            end
         end
         CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         FIX: begin
            // Overflow (most-negative / -1) falls out of truncating the magnitude here
            quotient_d  = (sign_a_q ^ sign_b_q) ? (-quo_q) : quo_q;
            remainder_d = sign_a_q ? (-rem_q) : rem_q;
            state_d     = DONE;
         end
         DONE: begin
            if (out_hs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // valid_out trails entry into DONE by one cycle and drops on the handshake edge
      valid_out_d = (state_q == DONE) && !out_hs;
      ready_in_d  = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         dvs_q         <= '0;
         sign_a_q      <= 1'b0;
         sign_b_q      <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
         valid_out_q   <= 1'b0;
         ready_in_q    <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rem_q         <= rem_d;
         quo_q         <= quo_d;
         dvs_q         <= dvs_d;
         sign_a_q      <= sign_a_d;
         sign_b_q      <= sign_b_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= div_by_zero_d;
         valid_out_q   <= valid_out_d;
         ready_in_q    <= ready_in_d;
      end
   end

   assign ready_in    = ready_in_q;
   assign valid_out   = valid_out_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed table-driven bench for seq_divider plus backpressure and mid-op reset sequences.
module tb_seq_divider;

   localparam int unsigned W = 16;

   logic         clk;
   logic         reset;
   logic         valid_in;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         ready_in;
   logic         valid_out;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int errors = 0;
   int checks = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .valid_in    (valid_in),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready_in    (ready_in),
      .valid_out   (valid_out),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int i;
      @(negedge clk);
      i = 0;
      while (!ready_in && i < 100) begin
         @(negedge clk);
         i++;
      end
      chk("ready_before_accept", 32'(ready_in), 32'd1);
      valid_in = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      dividend = 16'hDEAD;
      divisor  = 16'h0003;
   endtask

   task automatic wait_result(output int n);
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (valid_out) break;
      end
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(valid_out), 32'd0);
      chk({tag, "_ready_back"}, 32'(ready_in), 32'd1);
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                        input int lat);
      int n;
      start_op(a, b);
      wait_result(n);
      chk({tag, "_latency"}, 32'(n), 32'(lat));
      chk({tag, "_quotient"}, 32'(quotient), 32'(q));
      chk({tag, "_remainder"}, 32'(remainder), 32'(r));
      chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(dz));
      handshake(tag);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0]  = '{16'd100,  16'd7,      16'd14,     16'd2,      1'b0, 18};
      vecs[1]  = '{16'hFF9C, 16'd7,      16'hFFF2,   16'hFFFE,   1'b0, 18};
      vecs[2]  = '{16'd100,  16'hFFF9,   16'hFFF2,   16'd2,      1'b0, 18};
      vecs[3]  = '{16'd1234, 16'd0,      16'hFFFF,   16'd1234,   1'b1, 1};
      vecs[4]  = '{16'h8000, 16'hFFFF,   16'h8000,   16'd0,      1'b0, 18};
      vecs[5]  = '{16'd5,    16'd9,      16'd0,      16'd5,      1'b0, 18};
      vecs[6]  = '{16'hFFF9, 16'd2,      16'hFFFD,   16'hFFFF,   1'b0, 18};
      vecs[7]  = '{16'd0,    16'd5,      16'd0,      16'd0,      1'b0, 18};
      vecs[8]  = '{16'hFFFB, 16'd0,      16'hFFFF,   16'hFFFB,   1'b1, 1};
      vecs[9]  = '{16'h7FFF, 16'd1,      16'h7FFF,   16'd0,      1'b0, 18};
      vecs[10] = '{16'h8000, 16'd7,      16'hEDB7,   16'hFFFF,   1'b0, 18};

      reset     = 1'b1;
      valid_in  = 1'b0;
      dividend  = '0;
      divisor   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_ready_in", 32'(ready_in), 32'd1);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);

      for (int i = 0; i < 11; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
               vecs[i].dz, vecs[i].lat);
      end

      // Backpressure: a 50/5 offered during CALC must be ignored; result held 5 cycles
      start_op(16'd200, 16'd3);
      repeat (3) @(negedge clk);
      valid_in = 1'b1;
      dividend = 16'd50;
      divisor  = 16'd5;
      @(negedge clk);
      valid_in = 1'b0;
      wait_result(n);
      chk("bp_valid", 32'(valid_out), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d_valid", i), 32'(valid_out), 32'd1);
         chk($sformatf("bp_hold%0d_quotient", i), 32'(quotient), 32'd66);
         chk($sformatf("bp_hold%0d_remainder", i), 32'(remainder), 32'd2);
         chk($sformatf("bp_hold%0d_ready_in", i), 32'(ready_in), 32'd0);
      end
      handshake("bp");
      do_op("bp_next", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 18);

      // Reset six cycles into CALC discards the operation
      start_op(16'd1000, 16'd3);
      repeat (6) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_valid_out", 32'(valid_out), 32'd0);
      chk("midrst_quotient", 32'(quotient), 32'd0);
      chk("midrst_remainder", 32'(remainder), 32'd0);
      chk("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_ready_in", 32'(ready_in), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_no_stale_valid", 32'(valid_out), 32'd0);
      do_op("after_rst", 16'd81, 16'd9, 16'd9, 16'd0, 1'b0, 18);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
